// File: rtl/bn_relu_stage.sv
// rtl/bn_relu_stage.sv - batch-norm affine, saturation and ReLU stage feeding the output-image BRAM
//
// Purpose:
//    Sits directly after the conv2d engine. Each accepted pixel is multiplied by a
//    fixed-point scale, rounded half-up, offset by an integer bias, saturated to the
//    pixel range and optionally rectified. The result is written to the output-image
//    BRAM at consecutive word addresses; o_done pulses once the layer has drained.
//
// Optional build macro:
//    BN_RELU_LEAKY_EN - when defined, negative results with ReLU enabled become
//                       result >>> 3 (leaky slope 1/8) instead of 0. Latency unchanged.
//
// Ports:
//    i_clk, i_rst      clock, synchronous active-high reset
//    i_start           one-cycle start pulse, latches i_num_pix/i_scale/i_bias/i_relu_en
//    i_num_pix         pixels expected this layer
//    i_scale           signed scale, FRAC_BITS fractional bits
//    i_bias            signed bias, integer pixel units
//    i_relu_en         1 = apply ReLU after batch-norm
//    i_data, i_valid   pixel stream from conv2d (no backpressure)
//    i_up_done         upstream done pulse, ends the accept phase early
//    o_outimg_addr     output BRAM byte address
//    o_outimg_we       output BRAM write enable
//    o_outimg_data     zero-extended result word
//    o_busy            high whenever the FSM is not idle
//    o_sat             sticky: a result was clipped this layer
//    o_done            one-cycle completion pulse

module bn_relu_stage #(
   parameter int DATA_WIDTH = 16,
   parameter int FRAC_BITS  = 8,
   parameter int ADDR_WIDTH = 18
) (
   input  logic                  i_clk,
   input  logic                  i_rst,
   input  logic                  i_start,
   input  logic [ADDR_WIDTH-1:0] i_num_pix,
   input  logic [DATA_WIDTH-1:0] i_scale,
   input  logic [DATA_WIDTH-1:0] i_bias,
   input  logic                  i_relu_en,
   input  logic [DATA_WIDTH-1:0] i_data,
   input  logic                  i_valid,
   input  logic                  i_up_done,
   output logic [ADDR_WIDTH-1:0] o_outimg_addr,
   output logic                  o_outimg_we,
   output logic [31:0]           o_outimg_data,
   output logic                  o_busy,
   output logic                  o_sat,
   output logic                  o_done
);

   localparam int PW = 2 * DATA_WIDTH;
   // Two guard bits so rounding and bias addition can never wrap.
   localparam int SW = PW + 2;

   localparam logic signed [SW-1:0] RND =
      {{(SW-1){1'b0}}, 1'b1} << (FRAC_BITS - 1);
   localparam logic signed [SW-1:0] SAT_MAX =
      {{(SW-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
   localparam logic signed [SW-1:0] SAT_MIN =
      {{(SW-DATA_WIDTH+1){1'b1}}, {(DATA_WIDTH-1){1'b0}}};
   localparam logic [DATA_WIDTH-1:0] PIX_MAX = {1'b0, {(DATA_WIDTH-1){1'b1}}};
   localparam logic [DATA_WIDTH-1:0] PIX_MIN = {1'b1, {(DATA_WIDTH-1){1'b0}}};

   typedef enum logic [1:0] {
      S_IDLE,
      S_RUN,
      S_DRAIN,
      S_DONE
   } state_t;

   state_t                  state_q, state_d;
   logic [ADDR_WIDTH-1:0]   num_pix_q, num_pix_d;
   logic [DATA_WIDTH-1:0]   scale_q, scale_d;
   logic [DATA_WIDTH-1:0]   bias_q, bias_d;
   logic                    relu_q, relu_d;
   logic [ADDR_WIDTH-1:0]   count_q, count_d;
   logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
   logic                    sat_q, sat_d;

   logic                    v1_q, v1_d;
   logic [PW-1:0]           p1_q, p1_d;
   logic                    v2_q, v2_d;
   logic signed [SW-1:0]    s2_q, s2_d;
   logic                    v3_q, v3_d;
   logic [DATA_WIDTH-1:0]   res_q, res_d;

   logic                    accept;
   logic [PW-1:0]           mul_a, mul_b;
   logic signed [SW-1:0]    p_ext, rnd_sum, r_shift, bias_ext;
   logic signed [DATA_WIDTH-1:0] sat_val, act_val;
   logic                    clip;

   // Control FSM and layer bookkeeping
   always_comb begin
      state_d   = state_q;
      num_pix_d = num_pix_q;
      scale_d   = scale_q;
      bias_d    = bias_q;
      relu_d    = relu_q;
      count_d   = count_q;
      addr_d    = addr_q;
      sat_d     = sat_q;
      accept    = 1'b0;

      // Address steps in the cycle after each write; o_sat collects clips from S3.
      if (v3_q) begin
         addr_d = addr_q + ADDR_WIDTH'(4);
      end
      if (v2_q && clip) begin
         sat_d = 1'b1;
      end

      case (state_q)
         S_IDLE: begin
            if (i_start) begin
               num_pix_d = i_num_pix;
               scale_d   = i_scale;
               bias_d    = i_bias;
               relu_d    = i_relu_en;
               count_d   = '0;
               addr_d    = '0;
               sat_d     = 1'b0;
               state_d   = S_RUN;
            end
         end
         S_RUN: begin
            // count never exceeds num_pix, so num_pix=0 accepts nothing and leaves at once
            accept = i_valid && (count_q != num_pix_q);
            if (accept) begin
               count_d = count_q + ADDR_WIDTH'(1);
            end
            if ((count_q == num_pix_q) || i_up_done ||
                (accept && (count_d == num_pix_q))) begin
               state_d = S_DRAIN;
            end
         end
         S_DRAIN: begin
            if (!v1_q && !v2_q && !v3_q) begin
               state_d = S_DONE;
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // Datapath: S1 multiply, S2 round + bias, S3 saturate + activation
   always_comb begin
      // Sign-extend to full product width so the low PW bits of the product are the signed result.
      mul_a = {{DATA_WIDTH{i_data[DATA_WIDTH-1]}}, i_data};
      mul_b = {{DATA_WIDTH{scale_q[DATA_WIDTH-1]}}, scale_q};
      p1_d  = mul_a * mul_b;
      v1_d  = accept;

      p_ext    = {{(SW-PW){p1_q[PW-1]}}, p1_q};
      rnd_sum  = p_ext + RND;
      r_shift  = rnd_sum >>> FRAC_BITS;
      bias_ext = {{(SW-DATA_WIDTH){bias_q[DATA_WIDTH-1]}}, bias_q};
      s2_d     = r_shift + bias_ext;
      v2_d     = v1_q;

      clip    = 1'b0;
      sat_val = s2_q[DATA_WIDTH-1:0];
      if (s2_q > SAT_MAX) begin
         sat_val = PIX_MAX;
         clip    = 1'b1;
      end else if (s2_q < SAT_MIN) begin
         sat_val = PIX_MIN;
         clip    = 1'b1;
      end

      act_val = sat_val;
      if (relu_q && sat_val[DATA_WIDTH-1]) begin
`ifdef BN_RELU_LEAKY_EN
         act_val = sat_val >>> 3;
`else
         act_val = '0;
`endif
      end

      res_d = v2_q ? act_val : res_q;
      v3_d  = v2_q;
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q   <= S_IDLE;
         num_pix_q <= '0;
         scale_q   <= '0;
         bias_q    <= '0;
         relu_q    <= 1'b0;
         count_q   <= '0;
         addr_q    <= '0;
         sat_q     <= 1'b0;
         v1_q      <= 1'b0;
         p1_q      <= '0;
         v2_q      <= 1'b0;
         s2_q      <= '0;
         v3_q      <= 1'b0;
         res_q     <= '0;
      end else begin
         state_q   <= state_d;
         num_pix_q <= num_pix_d;
         scale_q   <= scale_d;
         bias_q    <= bias_d;
         relu_q    <= relu_d;
         count_q   <= count_d;
         addr_q    <= addr_d;
         sat_q     <= sat_d;
         v1_q      <= v1_d;
         p1_q      <= p1_d;
         v2_q      <= v2_d;
         s2_q      <= s2_d;
         v3_q      <= v3_d;
         res_q     <= res_d;
      end
   end

   assign o_outimg_addr = addr_q;
   assign o_outimg_we   = v3_q;
   assign o_outimg_data = {{(32-DATA_WIDTH){1'b0}}, res_q};
   assign o_busy        = (state_q != S_IDLE);
   assign o_sat         = sat_q;
   assign o_done        = (state_q == S_DONE);

endmodule

// File: tb/tb_bn_relu_stage.sv
// tb/tb_bn_relu_stage.sv - self-checking bench for bn_relu_stage (table vectors, sequences, random layers)
`timescale 1ns/1ps
module tb_bn_relu_stage;
   localparam int DW = 16;
   localparam int AW = 18;

   logic          i_clk = 1'b0;
   logic          i_rst, i_start, i_relu_en, i_valid, i_up_done;
   logic [AW-1:0] i_num_pix;
   logic [DW-1:0] i_scale, i_bias, i_data;
   logic [AW-1:0] o_outimg_addr;
   logic          o_outimg_we, o_busy, o_sat, o_done;
   logic [31:0]   o_outimg_data;

   always #5 i_clk = ~i_clk;

   bn_relu_stage #(.DATA_WIDTH(DW), .FRAC_BITS(8), .ADDR_WIDTH(AW)) dut (
      .i_clk(i_clk), .i_rst(i_rst), .i_start(i_start), .i_num_pix(i_num_pix),
      .i_scale(i_scale), .i_bias(i_bias), .i_relu_en(i_relu_en), .i_data(i_data),
      .i_valid(i_valid), .i_up_done(i_up_done), .o_outimg_addr(o_outimg_addr),
      .o_outimg_we(o_outimg_we), .o_outimg_data(o_outimg_data), .o_busy(o_busy),
      .o_sat(o_sat), .o_done(o_done)
   );

   int n_tests = 0;
   int n_fail  = 0;
   int cyc     = 0;
   int s_cyc   = 0;

   always @(posedge i_clk) cyc <= cyc + 1;

   typedef struct {
      int            c;
      logic [AW-1:0] addr;
      logic [31:0]   data;
   } wr_t;
   wr_t wr_q[$];
   int  done_q[$];

   always @(negedge i_clk) begin
      if (o_outimg_we) wr_q.push_back('{cyc, o_outimg_addr, o_outimg_data});
      if (o_done) done_q.push_back(cyc);
   end

   logic [15:0] beat[16];
   logic [15:0] exp_res[16];
   bit          exp_sat;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge i_clk);
      #1;
   endtask

   function automatic longint floor_div(input longint a, input longint b);
      longint q;
      q = a / b;
      if ((a % b != 0) && ((a < 0) != (b < 0))) q = q - 1;
      return q;
   endfunction

   // Reference: real-valued BN with round-half-up, clip to int16, then (leaky) ReLU.
   function automatic logic [16:0] model(input logic signed [15:0] d, input logic signed [15:0] sc,
                                         input logic signed [15:0] bi, input bit rl);
      longint v;
      bit     sat;
      v   = floor_div(longint'(d) * longint'(sc) + 128, 256) + longint'(bi);
      sat = 1'b0;
      if (v > 32767) begin v = 32767; sat = 1'b1; end
      else if (v < -32768) begin v = -32768; sat = 1'b1; end
      if (rl && v < 0) begin
`ifdef BN_RELU_LEAKY_EN
         v = floor_div(v, 8);
`else
         v = 0;
`endif
      end
      return {sat, v[15:0]};
   endfunction

   task automatic start_layer(input int np, input logic [15:0] sc, input logic [15:0] bi, input bit rl);
      i_start = 1'b1; i_num_pix = AW'(np); i_scale = sc; i_bias = bi; i_relu_en = rl;
      s_cyc = cyc;
      step();
      i_start = 1'b0;
   endtask

   // Runs one layer of nb beats (all accepted) and checks writes, timing, done, sat, addr.
   task automatic run_stream(input string tag, input int nb, input int np, input logic [15:0] sc,
                             input logic [15:0] bi, input bit rl, input bit updone_last,
                             input bit extra, input bit start_mid, input bit gaps);
      int t0[$];
      int exp_done;
      wr_q.delete(); done_q.delete();
      start_layer(np, sc, bi, rl);
      for (int i = 0; i < nb; i++) begin
         if (gaps) begin
            i_valid = 1'b0;
            repeat ($urandom_range(0, 2)) step();
         end
         i_valid = 1'b1; i_data = beat[i];
         i_up_done = updone_last && (i == nb - 1);
         if (start_mid && i == 1) begin i_start = 1'b1; i_num_pix = AW'(1); end
         t0.push_back(cyc);
         step();
         i_start = 1'b0; i_num_pix = AW'(np);
      end
      i_up_done = 1'b0;
      if (extra) begin i_valid = 1'b1; i_data = 16'h1234; step(); end
      i_valid = 1'b0;
      for (int w = 0; w < 30 && done_q.size() == 0; w++) step();
      repeat (3) step();
      check({tag, ".nwr"}, wr_q.size(), nb);
      for (int k = 0; k < nb && k < wr_q.size(); k++) begin
         check($sformatf("%s.addr%0d", tag, k), wr_q[k].addr, AW'(4 * k));
         check($sformatf("%s.data%0d", tag, k), wr_q[k].data, {16'h0, exp_res[k]});
         check($sformatf("%s.lat%0d", tag, k), wr_q[k].c, t0[k] + 3);
      end
      exp_done = (nb == 0) ? s_cyc + 3 : t0[nb - 1] + 5;
      check({tag, ".ndone"}, done_q.size(), 1);
      if (done_q.size() > 0) check({tag, ".done_cyc"}, done_q[0], exp_done);
      check({tag, ".sat"}, o_sat, exp_sat);
      check({tag, ".busy"}, o_busy, 1'b0);
      check({tag, ".addr_hold"}, o_outimg_addr, AW'(4 * nb));
   endtask

   typedef struct {
      logic [15:0] sc, bi;
      bit          rl;
      logic [15:0] d, exp;
      bit          sat;
   } vec_t;

   initial begin
      vec_t vt[11];
      logic [16:0] m;
      int nb;
      logic [15:0] sc, bi;
      bit rl;

      vt[0] = '{16'h0200, -16'sd50, 1'b0, 16'd100,     16'h0096, 1'b0};
`ifdef BN_RELU_LEAKY_EN
      vt[1] = '{16'h0100, 16'd0,    1'b1, -16'sd10,    16'hFFFE, 1'b0};
      vt[2] = '{16'h0100, 16'd0,    1'b1, -16'sd16,    16'hFFFE, 1'b0};
      vt[10] = '{16'h0200, 16'd0,   1'b1, -16'sd20000, 16'hF000, 1'b1};
`else
      vt[1] = '{16'h0100, 16'd0,    1'b1, -16'sd10,    16'h0000, 1'b0};
      vt[2] = '{16'h0100, 16'd0,    1'b1, -16'sd16,    16'h0000, 1'b0};
      vt[10] = '{16'h0200, 16'd0,   1'b1, -16'sd20000, 16'h0000, 1'b1};
`endif
      vt[3] = '{16'h0080, 16'd0,    1'b0, 16'd3,       16'h0002, 1'b0};
      vt[4] = '{16'h0080, 16'd0,    1'b0, -16'sd3,     16'hFFFF, 1'b0};
      vt[5] = '{16'h0200, 16'd0,    1'b0, 16'd20000,   16'h7FFF, 1'b1};
      vt[6] = '{16'h0200, 16'd0,    1'b0, -16'sd20000, 16'h8000, 1'b1};
      vt[7] = '{16'h0100, 16'd100,  1'b0, 16'h7FFF,    16'h7FFF, 1'b1};
      vt[8] = '{16'h0100, -16'sd1,  1'b0, 16'h8000,    16'h8000, 1'b1};
      vt[9] = '{16'hFF00, 16'd0,    1'b0, 16'd300,     16'hFED4, 1'b0};

      i_rst = 1'b1; i_start = 1'b0; i_num_pix = '0; i_scale = '0; i_bias = '0;
      i_relu_en = 1'b0; i_data = '0; i_valid = 1'b0; i_up_done = 1'b0;
      step(); step();
      i_rst = 1'b0;
      i_valid = 1'b1; i_data = 16'h0055;
      step();
      i_valid = 1'b0;
      check("rst.addr", o_outimg_addr, '0);
      check("rst.we", o_outimg_we, 1'b0);
      check("rst.data", o_outimg_data, 32'h0);
      check("rst.busy", o_busy, 1'b0);
      check("rst.sat", o_sat, 1'b0);
      check("rst.done", o_done, 1'b0);
      repeat (4) step();
      check("idle.nwr", wr_q.size(), 0);

      // single-pixel vectors
      for (int i = 0; i < 11; i++) begin
         beat[0] = vt[i].d; exp_res[0] = vt[i].exp; exp_sat = vt[i].sat;
         run_stream($sformatf("vec%0d", i), 1, 1, vt[i].sc, vt[i].bi, vt[i].rl, 1'b0, 1'b0, 1'b0, 1'b0);
      end

      // reset in the middle of a run: prior layer left o_sat set and addr at 4
      wr_q.delete(); done_q.delete();
      start_layer(8, 16'h0100, 16'd0, 1'b0);
      check("rstmid.busy_run", o_busy, 1'b1);
      i_valid = 1'b1; i_data = 16'd5; step();
      i_data = 16'd6; step();
      i_valid = 1'b0; i_rst = 1'b1; step();
      i_rst = 1'b0;
      repeat (10) step();
      check("rstmid.nwr", wr_q.size(), 0);
      check("rstmid.ndone", done_q.size(), 0);
      check("rstmid.busy", o_busy, 1'b0);
      check("rstmid.addr", o_outimg_addr, '0);
      check("rstmid.sat", o_sat, 1'b0);

      // streaming: 4 beats, 5th beat falls in DRAIN
      for (int i = 0; i < 4; i++) begin
         beat[i] = 16'(i * 7 + 1);
         m = model(beat[i], 16'h0100, 16'd3, 1'b0);
         exp_res[i] = m[15:0];
      end
      exp_sat = 1'b0;
      run_stream("stream", 4, 4, 16'h0100, 16'd3, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);

      // early termination with i_start pulsed while busy
      for (int i = 0; i < 4; i++) begin
         beat[i] = 16'(-100 + 60 * i);
         m = model(beat[i], 16'h0180, -16'sd20, 1'b1);
         exp_res[i] = m[15:0];
      end
      exp_sat = 1'b0;
      run_stream("early", 4, 10, 16'h0180, -16'sd20, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);

      // empty layer
      exp_sat = 1'b0;
      run_stream("zero", 0, 0, 16'h0100, 16'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

      // randomized layers
      for (int l = 0; l < 8; l++) begin
         nb = $urandom_range(1, 8);
         if (l % 2 == 0) begin
            sc = 16'($urandom);
            bi = 16'($urandom);
         end else begin
            sc = 16'($signed($urandom_range(0, 1023)) - 512);
            bi = 16'($signed($urandom_range(0, 400)) - 200);
         end
         rl = 1'($urandom);
         exp_sat = 1'b0;
         for (int i = 0; i < nb; i++) begin
            beat[i] = (l % 2 == 0) ? 16'($urandom) : 16'($signed($urandom_range(0, 8000)) - 4000);
            m = model(beat[i], sc, bi, rl);
            exp_res[i] = m[15:0];
            exp_sat = exp_sat | m[16];
         end
         run_stream($sformatf("rand%0d", l), nb, nb, sc, bi, rl, 1'b0, 1'b0, 1'b0, 1'b1);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #3_000_000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end
endmodule
